alu_op_sequencer: RTL and testbench
===================================

// Module: alu_op_sequencer
// PURPOSE
//  Issue-side front end for the 16-bit ALU. Accepts 15-bit two's-complement requests on a valid/ready port.
//  Encodes operands into the ALU operand format: 15-bit ones'-complement value in [15:1], bit 0 = 0.
//  Drives the ALU command, captures its 15-bit result and decodes it back to two's complement.
//  Runs two ALU passes for a full 30-bit multiply (MP0/MP1) and for quotient+remainder (DV1/DV0).
// PARAMETERS
//  SETTLE_CYCLES  1  cycles alu_* held stable before alu_res is sampled (>=1)
// PORTS
//  clk        in   1   clock, rising edge
//  reset      in   1   synchronous, active-high
//  req_valid  in   1   request valid
//  req_ready  out  1   request accepted when req_valid & req_ready
//  req_op     in   3   0 ADD, 1 SUB, 2 AND, 3 MUL, 4 DIVMOD; 5-7 -> rsp_err
//  req_a      in   15  operand A, two's complement
//  req_b      in   15  operand B, two's complement
//  alu_a      out  16  ALU operand A, registered
//  alu_b      out  16  ALU operand B, registered
//  alu_cmd    out  3   ALU command, registered
//  alu_res    in   15  ALU result, combinational from alu_*
//  rsp_valid  out  1   response valid, held until rsp_ready
//  rsp_ready  in   1   response consumer ready
//  rsp_lo     out  15  result / product[14:0] / quotient
//  rsp_hi     out  15  sign-extension / product[29:15] / remainder
//  rsp_err    out  1   error flag for this response
// BEHAVIOUR
//  Reset: req_ready=0 during reset, 1 in the first IDLE cycle after; rsp_valid=0, rsp_*=0, alu_a=alu_b=0, alu_cmd=0.
//  FSM states: IDLE -> PH1 -> [PH2] -> RESP -> IDLE. req_ready=1 only in IDLE.
//  Accept edge E0:
//   - Operands registered; phase-1 alu_* driven from E0.
//   - Each phase lasts SETTLE_CYCLES cycles; alu_res is sampled on the phase's last edge.
//  Latency: rsp_valid rises on edge E0 + phases*SETTLE_CYCLES + 1 (1 or 2 phases).
//  ADD/SUB/AND: one phase, alu_cmd=0/1/2.
//   - Positive x -> {x,1'b0}; negative x -> {~(-x),1'b0}.
//   - ADD/SUB decode: alu_res[14]=1 -> alu_res+1, else alu_res. rsp_hi = sign extension.
//   - AND: raw alu_res; rsp_hi=0.
//  MUL: two phases, alu_cmd=3 then 4; operands sent as magnitudes with sign bit 0.
//   - p={res2,res1} is a 30-bit magnitude; negated when the operand signs differ.
//   - {rsp_hi,rsp_lo} = 30-bit two's-complement product.
//  DIVMOD: magnitudes sent; phase 1 alu_cmd=6 (quotient), phase 2 alu_cmd=5 (remainder).
//   - Truncating division: quotient negative if signs differ; remainder takes the dividend's sign.
//   - rsp_lo=quotient, rsp_hi=remainder.
//  Errors (no ALU phase issued, alu_* unchanged; RESP on edge E0+1 with rsp_lo=rsp_hi=0, rsp_err=1):
//   - either operand = -16384 (0x4000): not representable in ones' complement;
//   - DIVMOD with req_b=0; req_op>4.
//  RESP: rsp_* stable while rsp_valid & !rsp_ready; leave on handshake edge.
//   - Request presented during the handshake cycle is taken in the next IDLE cycle (no same-cycle turnaround).
//  Reset mid-operation: in-flight request discarded, no response, all outputs to reset values.
// CONFIGURATION
//  ALU_SEQ_OVF_EN defined:
//   - ADD/SUB result computed in 16 bits alongside the ALU pass; outside [-16383,16383] -> rsp_err=1.
//   - Values still returned as decoded.
//  Undefined: no overflow check; rsp_err only for the error cases above; wrapped value returned.
// TESTING
//  ADD 5 + -3 -> alu_a=0x000A, alu_b=0xFFF8, alu_cmd=0; rsp_lo=2, rsp_hi=0, err=0; rsp_valid at E0+2 (SETTLE=1).
//  MUL -300*200 -> alu_cmd 3 then 4; rsp_hi=0x7FFE, rsp_lo=0x15A0 (-60000), err=0; rsp_valid at E0+3.
//  DIVMOD -17/5 -> alu_cmd 6 then 5; rsp_lo=0x7FFD (-3), rsp_hi=0x7FFE (-2), err=0.
//  DIVMOD 7/0 and ADD -16384+1 -> no alu_cmd change; rsp_err=1, rsp_lo=rsp_hi=0 at E0+1.
//  Backpressure: rsp_ready low 4 cycles -> rsp_* stable, req_ready=0; new req accepted the cycle after the handshake.
//  Reset asserted mid-MUL phase 2 -> no rsp_valid, alu_*=0; next request completes normally.
//  ALU_SEQ_OVF_EN: ADD 16000+1000 -> rsp_err=1; without the macro -> rsp_err=0.

Source files
------------

// File: rtl/alu_op_sequencer.sv
// Purpose: issue-side front end for the 16-bit ones'-complement ALU (encode, sequence, decode).
// Latency: rsp_valid_o rises phases*SETTLE_CYCLES+1 edges after accept; rejected requests after 1 edge.
// Backpressure: one request in flight; req_ready_o only in IDLE; response held until rsp_ready_i.
// Optional: define ALU_SEQ_OVF_EN to flag ADD/SUB results outside [-16383,16383] with rsp_err_o.
module alu_op_sequencer #(
  parameter int SETTLE_CYCLES = 1
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic [2:0]  req_op_i,
  input  logic [14:0] req_a_i,
  input  logic [14:0] req_b_i,
  output logic [15:0] alu_a_o,
  output logic [15:0] alu_b_o,
  output logic [2:0]  alu_cmd_o,
  input  logic [14:0] alu_res_i,
  output logic        rsp_valid_o,
  input  logic        rsp_ready_i,
  output logic [14:0] rsp_lo_o,
  output logic [14:0] rsp_hi_o,
  output logic        rsp_err_o
);

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_AND = 3'd2;
  localparam logic [2:0] OP_MUL = 3'd3;
  localparam logic [2:0] OP_DIV = 3'd4;

  localparam logic [2:0] CMD_ADD    = 3'd0;
  localparam logic [2:0] CMD_SUB    = 3'd1;
  localparam logic [2:0] CMD_AND    = 3'd2;
  localparam logic [2:0] CMD_MUL_LO = 3'd3;
  localparam logic [2:0] CMD_MUL_HI = 3'd4;
  localparam logic [2:0] CMD_REM    = 3'd5;
  localparam logic [2:0] CMD_QUO    = 3'd6;

  localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_CYCLES - 1);

  // DONE is the single cycle in which the captured result is decoded into rsp_*.
  typedef enum logic [2:0] {
    S_IDLE,
    S_PH1,
    S_PH2,
    S_DONE,
    S_RESP
  } state_t;

  // Signed 15-bit value -> ALU operand: ones'-complement in [15:1], bit 0 zero.
  function automatic logic [15:0] enc_ones(input logic [14:0] x);
    logic [14:0] neg;
    neg = -x;
    return x[14] ? {~neg, 1'b0} : {x, 1'b0};
  endfunction

  // Signed 15-bit value -> ALU operand carrying only the magnitude (sign bit 0).
  function automatic logic [15:0] enc_mag(input logic [14:0] x);
    logic [14:0] neg;
    neg = -x;
    return x[14] ? {neg, 1'b0} : {x, 1'b0};
  endfunction

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       op_q, op_d;
  logic             a_neg_q, a_neg_d;
  logic             b_neg_q, b_neg_d;
  logic             err_q, err_d;
  logic [14:0]      res1_q, res1_d;
  logic [14:0]      res2_q, res2_d;
  logic [15:0]      alu_a_q, alu_a_d;
  logic [15:0]      alu_b_q, alu_b_d;
  logic [2:0]       alu_cmd_q, alu_cmd_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic [14:0]      rsp_lo_q, rsp_lo_d;
  logic [14:0]      rsp_hi_q, rsp_hi_d;
  logic             rsp_err_q, rsp_err_d;

  logic             req_err;
  logic             phase_last;
  logic [14:0]      dec_lo, dec_hi;
  logic             dec_err;
  logic [14:0]      addsub_lo;
  logic [29:0]      prod_mag, prod;
  logic [14:0]      res1_neg, res2_neg;

  // -16384 has no ones'-complement encoding; zero divisor and unknown ops are rejected too.
  assign req_err = (req_a_i == 15'h4000) || (req_b_i == 15'h4000) ||
                   (req_op_i > OP_DIV) ||
                   ((req_op_i == OP_DIV) && (req_b_i == 15'd0));

  assign phase_last  = (cnt_q == CNT_LAST);
  assign req_ready_o = (state_q == S_IDLE) && !reset_i;

  assign alu_a_o     = alu_a_q;
  assign alu_b_o     = alu_b_q;
  assign alu_cmd_o   = alu_cmd_q;
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_lo_o    = rsp_lo_q;
  assign rsp_hi_o    = rsp_hi_q;
  assign rsp_err_o   = rsp_err_q;

`ifdef ALU_SEQ_OVF_EN
  logic [15:0] req_a_sx, req_b_sx, req_sum;
  logic        req_ovf;
  logic        ovf_q, ovf_d;

  // True 16-bit sum/difference, evaluated at accept alongside the ALU pass.
  assign req_a_sx = {req_a_i[14], req_a_i};
  assign req_b_sx = {req_b_i[14], req_b_i};
  assign req_sum  = (req_op_i == OP_SUB) ? (req_a_sx - req_b_sx) : (req_a_sx + req_b_sx);
  assign req_ovf  = ($signed(req_sum) > 16'sd16383) || ($signed(req_sum) < -16'sd16383);
`endif

  // Decode the captured ALU result(s) back into two's-complement response fields.
  always_comb begin
    dec_lo    = '0;
    dec_hi    = '0;
    dec_err   = err_q;
    addsub_lo = res1_q[14] ? (res1_q + 15'd1) : res1_q;
    prod_mag  = {res2_q, res1_q};
    prod      = (a_neg_q ^ b_neg_q) ? (~prod_mag + 30'd1) : prod_mag;
    res1_neg  = -res1_q;
    res2_neg  = -res2_q;
    if (!err_q) begin
      case (op_q)
        OP_ADD, OP_SUB: begin
          dec_lo = addsub_lo;
          dec_hi = {15{addsub_lo[14]}};
`ifdef ALU_SEQ_OVF_EN
          dec_err = ovf_q;
`endif
        end
        OP_AND: begin
          dec_lo = res1_q;
        end
        OP_MUL: begin
          dec_lo = prod[14:0];
          dec_hi = prod[29:15];
        end
        OP_DIV: begin
          // Truncating division: quotient sign from both operands, remainder follows the dividend.
          dec_lo = (a_neg_q ^ b_neg_q) ? res1_neg : res1_q;
          dec_hi = a_neg_q ? res2_neg : res2_q;
        end
        default: begin
          dec_lo = '0;
        end
      endcase
    end
  end

  // Next-state and datapath update for the accept/phase/decode/response sequence.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    op_d        = op_q;
    a_neg_d     = a_neg_q;
    b_neg_d     = b_neg_q;
    err_d       = err_q;
    res1_d      = res1_q;
    res2_d      = res2_q;
    alu_a_d     = alu_a_q;
    alu_b_d     = alu_b_q;
    alu_cmd_d   = alu_cmd_q;
    rsp_valid_d = rsp_valid_q;
    rsp_lo_d    = rsp_lo_q;
    rsp_hi_d    = rsp_hi_q;
    rsp_err_d   = rsp_err_q;
`ifdef ALU_SEQ_OVF_EN
    ovf_d       = ovf_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (req_valid_i && req_ready_o) begin
          op_d    = req_op_i;
          a_neg_d = req_a_i[14];
          b_neg_d = req_b_i[14];
          err_d   = req_err;
          cnt_d   = '0;
`ifdef ALU_SEQ_OVF_EN
          ovf_d   = req_ovf;
`endif
          if (req_err) begin
            // Rejected: ALU outputs are left untouched.
            state_d = S_DONE;
          end else begin
            state_d = S_PH1;
            case (req_op_i)
              OP_ADD: begin
                alu_a_d   = enc_ones(req_a_i);
                alu_b_d   = enc_ones(req_b_i);
                alu_cmd_d = CMD_ADD;
              end
              OP_SUB: begin
                alu_a_d   = enc_ones(req_a_i);
                alu_b_d   = enc_ones(req_b_i);
                alu_cmd_d = CMD_SUB;
              end
              OP_AND: begin
                alu_a_d   = enc_ones(req_a_i);
                alu_b_d   = enc_ones(req_b_i);
                alu_cmd_d = CMD_AND;
              end
              OP_MUL: begin
                alu_a_d   = enc_mag(req_a_i);
                alu_b_d   = enc_mag(req_b_i);
                alu_cmd_d = CMD_MUL_LO;
              end
              default: begin
                alu_a_d   = enc_mag(req_a_i);
                alu_b_d   = enc_mag(req_b_i);
                alu_cmd_d = CMD_QUO;
              end
            endcase
          end
        end
      end

      S_PH1: begin
        if (phase_last) begin
          res1_d = alu_res_i;
          cnt_d  = '0;
          if (op_q == OP_MUL) begin
            alu_cmd_d = CMD_MUL_HI;
            state_d   = S_PH2;
          end else if (op_q == OP_DIV) begin
            alu_cmd_d = CMD_REM;
            state_d   = S_PH2;
          end else begin
            state_d = S_DONE;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      S_PH2: begin
        if (phase_last) begin
          res2_d  = alu_res_i;
          cnt_d   = '0;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      S_DONE: begin
        rsp_lo_d    = dec_lo;
        rsp_hi_d    = dec_hi;
        rsp_err_d   = dec_err;
        rsp_valid_d = 1'b1;
        state_d     = S_RESP;
      end

      S_RESP: begin
        if (rsp_ready_i) begin
          rsp_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset drops any in-flight request and zeroes every output.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      op_q        <= OP_ADD;
      a_neg_q     <= 1'b0;
      b_neg_q     <= 1'b0;
      err_q       <= 1'b0;
      res1_q      <= '0;
      res2_q      <= '0;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      alu_cmd_q   <= '0;
      rsp_valid_q <= 1'b0;
      rsp_lo_q    <= '0;
      rsp_hi_q    <= '0;
      rsp_err_q   <= 1'b0;
`ifdef ALU_SEQ_OVF_EN
      ovf_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      op_q        <= op_d;
      a_neg_q     <= a_neg_d;
      b_neg_q     <= b_neg_d;
      err_q       <= err_d;
      res1_q      <= res1_d;
      res2_q      <= res2_d;
      alu_a_q     <= alu_a_d;
      alu_b_q     <= alu_b_d;
      alu_cmd_q   <= alu_cmd_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_lo_q    <= rsp_lo_d;
      rsp_hi_q    <= rsp_hi_d;
      rsp_err_q   <= rsp_err_d;
`ifdef ALU_SEQ_OVF_EN
      ovf_q       <= ovf_d;
`endif
    end
  end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Bench for alu_op_sequencer: behavioural ALU plus an integer-arithmetic reference model.
// Directed cases from the block's examples, then randomized requests with random backpressure.
// Checks reset values, encodings, ALU command sequence, latency, response values and hold.
module tb_alu_op_sequencer;

  localparam int S = 1;

  logic        clk;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  req_op;
  logic [14:0] req_a;
  logic [14:0] req_b;
  logic [15:0] alu_a;
  logic [15:0] alu_b;
  logic [2:0]  alu_cmd;
  logic [14:0] alu_res;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [14:0] rsp_lo;
  logic [14:0] rsp_hi;
  logic        rsp_err;

  int checks = 0;
  int failures = 0;

  alu_op_sequencer #(.SETTLE_CYCLES(S)) dut (
    .clk_i       (clk),
    .reset_i     (reset),
    .req_valid_i (req_valid),
    .req_ready_o (req_ready),
    .req_op_i    (req_op),
    .req_a_i     (req_a),
    .req_b_i     (req_b),
    .alu_a_o     (alu_a),
    .alu_b_o     (alu_b),
    .alu_cmd_o   (alu_cmd),
    .alu_res_i   (alu_res),
    .rsp_valid_o (rsp_valid),
    .rsp_ready_i (rsp_ready),
    .rsp_lo_o    (rsp_lo),
    .rsp_hi_o    (rsp_hi),
    .rsp_err_o   (rsp_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural ALU: ones'-complement add/sub with end-around carry, raw AND, magnitude mul/div.
  logic [14:0] fa, fb;
  logic [15:0] tsum;
  logic [29:0] tprod;
  always_comb begin
    fa      = alu_a[15:1];
    fb      = alu_b[15:1];
    tsum    = '0;
    tprod   = '0;
    alu_res = '0;
    case (alu_cmd)
      3'd0: begin
        tsum    = {1'b0, fa} + {1'b0, fb};
        alu_res = tsum[14:0] + {14'd0, tsum[15]};
      end
      3'd1: begin
        tsum    = {1'b0, fa} + {1'b0, ~fb};
        alu_res = tsum[14:0] + {14'd0, tsum[15]};
      end
      3'd2: alu_res = fa & fb;
      3'd3: begin
        tprod   = {15'd0, fa} * {15'd0, fb};
        alu_res = tprod[14:0];
      end
      3'd4: begin
        tprod   = {15'd0, fa} * {15'd0, fb};
        alu_res = tprod[29:15];
      end
      3'd5: alu_res = (fb != 15'd0) ? (fa % fb) : 15'd0;
      3'd6: alu_res = (fb != 15'd0) ? (fa / fb) : 15'd0;
      default: alu_res = '0;
    endcase
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int ones15(input int x);
    return (x >= 0) ? x : 32767 + x;
  endfunction

  function automatic int iabs(input int x);
    return (x < 0) ? -x : x;
  endfunction

  // Reference: the arithmetic the request asks for, in plain integers.
  function automatic void ref_model(input logic [2:0] op, input logic [14:0] a, input logic [14:0] b,
                                    output logic [14:0] lo, output logic [14:0] hi, output logic err,
                                    output int phases, output logic [2:0] c1, output logic [2:0] c2,
                                    output logic [15:0] ea, output logic [15:0] eb);
    int ai, bi, s, w, p;
    logic [29:0] pv;
    ai = $signed(a);
    bi = $signed(b);
    lo = '0; hi = '0; err = 1'b0; phases = 1; c1 = 3'd0; c2 = 3'd0; ea = '0; eb = '0;
    if (ai == -16384 || bi == -16384 || op > 3'd4 || (op == 3'd4 && bi == 0)) begin
      err = 1'b1;
      phases = 0;
      return;
    end
    case (op)
      3'd0, 3'd1: begin
        s  = (op == 3'd0) ? ai + bi : ai - bi;
        w  = (s > 16383) ? s - 32767 : ((s < -16383) ? s + 32767 : s);
        lo = 15'(w);
        hi = (w < 0) ? 15'h7FFF : 15'h0000;
`ifdef ALU_SEQ_OVF_EN
        err = (s > 16383) || (s < -16383);
`endif
        c1 = op;
        ea = 16'(ones15(ai) * 2);
        eb = 16'(ones15(bi) * 2);
      end
      3'd2: begin
        lo = 15'(ones15(ai) & ones15(bi));
        c1 = 3'd2;
        ea = 16'(ones15(ai) * 2);
        eb = 16'(ones15(bi) * 2);
      end
      3'd3: begin
        p  = ai * bi;
        pv = 30'(p);
        lo = pv[14:0];
        hi = pv[29:15];
        phases = 2; c1 = 3'd3; c2 = 3'd4;
        ea = 16'(iabs(ai) * 2);
        eb = 16'(iabs(bi) * 2);
      end
      default: begin
        lo = 15'(ai / bi);
        hi = 15'(ai % bi);
        phases = 2; c1 = 3'd6; c2 = 3'd5;
        ea = 16'(iabs(ai) * 2);
        eb = 16'(iabs(bi) * 2);
      end
    endcase
  endfunction

  // One full transaction, entered and left at a negedge with the DUT idle.
  task automatic do_req(input logic [2:0] op, input logic [14:0] a, input logic [14:0] b, input int hold,
                        output logic [14:0] lo, output logic [14:0] hi, output logic err);
    logic [14:0] xlo, xhi;
    logic        xerr;
    int          ph, lat, waited;
    logic [2:0]  c1, c2, pc;
    logic [15:0] ea, eb, pa, pb;
    ref_model(op, a, b, xlo, xhi, xerr, ph, c1, c2, ea, eb);
    req_op = op; req_a = a; req_b = b; req_valid = 1'b1;
    waited = 0;
    while (!req_ready && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    check("req_ready_idle", req_ready, 1);
    pa = alu_a; pb = alu_b; pc = alu_cmd;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0; req_op = 3'($urandom); req_a = 15'($urandom); req_b = 15'($urandom);
    check("req_ready_busy", req_ready, 0);
    if (ph == 0) begin
      check("alu_a_unchanged", alu_a, pa);
      check("alu_b_unchanged", alu_b, pb);
      check("alu_cmd_unchanged", alu_cmd, pc);
    end else begin
      check("alu_a_enc", alu_a, ea);
      check("alu_b_enc", alu_b, eb);
      check("alu_cmd_ph1", alu_cmd, c1);
    end
    lat = 0;
    while (!rsp_valid && lat < 40) begin
      @(posedge clk);
      @(negedge clk);
      lat++;
      if (ph == 2 && lat == S) check("alu_cmd_ph2", alu_cmd, c2);
    end
    check("latency", lat, (ph == 0) ? 1 : ph * S + 1);
    lo = rsp_lo; hi = rsp_hi; err = rsp_err;
    check("rsp_lo", lo, xlo);
    check("rsp_hi", hi, xhi);
    check("rsp_err", err, xerr);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      @(negedge clk);
      check("hold_valid", rsp_valid, 1);
      check("hold_lo", rsp_lo, lo);
      check("hold_hi", rsp_hi, hi);
      check("hold_err", rsp_err, err);
      check("hold_req_ready", req_ready, 0);
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rsp_ready = 1'b0;
    check("post_hs_valid", rsp_valid, 0);
    check("post_hs_req_ready", req_ready, 1);
  endtask

  function automatic logic [14:0] pick_operand();
    int r;
    r = $urandom_range(0, 15);
    case (r)
      0: return 15'h4000;
      1: return 15'h0000;
      2: return 15'h3FFF;
      3: return 15'h4001;
      4: return 15'h7FFF;
      default: return 15'($urandom);
    endcase
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog observed=running expected=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [14:0] lo, hi;
    logic        err;
    logic [2:0]  op;
    int          waited;

    reset = 1'b1; req_valid = 1'b0; rsp_ready = 1'b0;
    req_op = '0; req_a = '0; req_b = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_req_ready", req_ready, 0);
    check("reset_rsp_valid", rsp_valid, 0);
    check("reset_alu_a", alu_a, 0);
    check("reset_alu_b", alu_b, 0);
    check("reset_alu_cmd", alu_cmd, 0);
    check("reset_rsp_lo", rsp_lo, 0);
    check("reset_rsp_hi", rsp_hi, 0);
    check("reset_rsp_err", rsp_err, 0);
    reset = 1'b0;
    @(negedge clk);
    check("first_idle_req_ready", req_ready, 1);

    do_req(3'd0, 15'd5, 15'(-3), 0, lo, hi, err);
    check("add_alu_a", alu_a, 16'h000A);
    check("add_alu_b", alu_b, 16'hFFF8);
    check("add_lo", lo, 15'd2);
    check("add_hi", hi, 15'd0);
    check("add_err", err, 0);

    do_req(3'd3, 15'(-300), 15'd200, 0, lo, hi, err);
    check("mul_lo", lo, 15'h15A0);
    check("mul_hi", hi, 15'h7FFE);
    check("mul_err", err, 0);

    do_req(3'd4, 15'(-17), 15'd5, 1, lo, hi, err);
    check("div_lo", lo, 15'h7FFD);
    check("div_hi", hi, 15'h7FFE);

    do_req(3'd4, 15'd7, 15'd0, 0, lo, hi, err);
    check("div0_err", err, 1);
    check("div0_lo", lo, 0);

    do_req(3'd0, 15'h4000, 15'd1, 0, lo, hi, err);
    check("minval_err", err, 1);

    do_req(3'd6, 15'd1, 15'd1, 0, lo, hi, err);
    check("badop_err", err, 1);

    do_req(3'd0, 15'd16000, 15'd1000, 0, lo, hi, err);
`ifdef ALU_SEQ_OVF_EN
    check("ovf_err", err, 1);
`else
    check("ovf_err", err, 0);
`endif

    do_req(3'd2, 15'h1234, 15'(-77), 4, lo, hi, err);

    // Reset in the middle of a MUL second phase.
    req_op = 3'd3; req_a = 15'd123; req_b = 15'(-456); req_valid = 1'b1;
    waited = 0;
    while (!req_ready && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    repeat (S) @(posedge clk);
    @(negedge clk);
    check("midrst_ph2_cmd", alu_cmd, 3'd4);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("midrst_req_ready", req_ready, 0);
    check("midrst_alu_a", alu_a, 0);
    check("midrst_alu_b", alu_b, 0);
    check("midrst_alu_cmd", alu_cmd, 0);
    check("midrst_rsp_valid", rsp_valid, 0);
    check("midrst_rsp_lo", rsp_lo, 0);
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      @(negedge clk);
      check("midrst_no_rsp", rsp_valid, 0);
    end
    check("midrst_idle", req_ready, 1);
    do_req(3'd3, 15'd123, 15'(-456), 0, lo, hi, err);

    for (int n = 0; n < 80; n++) begin
      op = ($urandom_range(0, 9) < 9) ? 3'($urandom_range(0, 4)) : 3'($urandom_range(5, 7));
      do_req(op, pick_operand(), pick_operand(), $urandom_range(0, 3), lo, hi, err);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
